// File: rtl/exc_ctrl_if.sv
// M-stage side bus of the exception/interrupt controller.
// master = pipeline/M stage, slave = exc_ctrl.
interface exc_ctrl_if;
  logic [31:0] pc_M;
  logic        bd_M;
  logic [4:0]  exccode_M;
  logic        eret_M;
  logic        mtc0_we_M;
  logic [4:0]  cp0_addr_M;
  logic [31:0] cp0_wdata_M;
  logic [5:0]  hwint;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] cp0_rdata;
  logic        exl;

  modport master (
    output pc_M, bd_M, exccode_M, eret_M,
    output mtc0_we_M, cp0_addr_M, cp0_wdata_M,
    output hwint,
    input  req, epc_out, cp0_rdata, exl
  );

  modport slave (
    input  pc_M, bd_M, exccode_M, eret_M,
    input  mtc0_we_M, cp0_addr_M, cp0_wdata_M,
    input  hwint,
    output req, epc_out, cp0_rdata, exl
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller with CP0 SR/Cause/EPC/PRId.
// Ports: clk, reset (sync, active-high), bus (exc_ctrl_if.slave).
// Option macro EXC_CTRL_IRQ_SYNC_EN: 2-flop hwint synchroniser.
module exc_ctrl #(
  parameter logic [31:0] PRID = 32'h2022_0707
) (
  input  logic       clk,
  input  logic       reset,
  exc_ctrl_if.slave  bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  ip_in;
  logic        irq, exc, req;
  logic        wr_sr, wr_epc;
  logic [31:0] sr_val, cause_val;

`ifdef EXC_CTRL_IRQ_SYNC_EN
  logic [5:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.hwint;
      sync2_q <= sync1_q;
    end
  end

  assign ip_in = sync2_q;
`else
  assign ip_in = bus.hwint;
`endif

  assign irq = ie_q & ~exl_q & (|(ip_in & im_q));
  assign exc = ~exl_q & (bus.exccode_M != 5'd0);
  assign req = irq | exc;

  // Aborted instructions must not commit their mtc0.
  assign wr_sr  = bus.mtc0_we_M & ~req
                & (bus.cp0_addr_M == 5'd12);
  assign wr_epc = bus.mtc0_we_M & ~req
                & (bus.cp0_addr_M == 5'd14);

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ip_d   = ip_in;
    code_d = code_q;
    epc_d  = epc_q;
    if (req) begin
      exl_d  = 1'b1;
      bd_d   = bus.bd_M;
      epc_d  = bus.bd_M ? bus.pc_M - 32'd4
                        : bus.pc_M;
      code_d = irq ? 5'd0 : bus.exccode_M;
    end else begin
      if (wr_sr) begin
        im_d  = bus.cp0_wdata_M[15:10];
        exl_d = bus.cp0_wdata_M[1];
        ie_d  = bus.cp0_wdata_M[0];
      end
      if (wr_epc) begin
        epc_d = bus.cp0_wdata_M;
      end
      // eret wins over a same-cycle SR write of EXL.
      if (bus.eret_M) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  assign sr_val = {16'h0, im_q, 8'h0,
                   exl_q, ie_q};
  assign cause_val = {bd_q, 15'h0, ip_q,
                      3'h0, code_q, 2'h0};

  always_comb begin
    bus.cp0_rdata = 32'h0;
    case (bus.cp0_addr_M)
      5'd12:   bus.cp0_rdata = sr_val;
      5'd13:   bus.cp0_rdata = cause_val;
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = PRID;
      default: bus.cp0_rdata = 32'h0;
    endcase
  end

  assign bus.epc_out =
    (bus.mtc0_we_M && bus.cp0_addr_M == 5'd14)
      ? bus.cp0_wdata_M : epc_q;
  assign bus.req = req;
  assign bus.exl = exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
// Default build (hwint used directly, no synchroniser).
module tb_exc_ctrl;
  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  exc_ctrl_if bus ();

  exc_ctrl #(.PRID(32'h2022_0707)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %08h want %08h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    bus.cp0_addr_M = a;
    #1;
    chk(tag, bus.cp0_rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pc_M        = 32'h0000_3000;
    bus.bd_M        = 1'b0;
    bus.exccode_M   = 5'd0;
    bus.eret_M      = 1'b0;
    bus.mtc0_we_M   = 1'b0;
    bus.cp0_addr_M  = 5'd0;
    bus.cp0_wdata_M = 32'h0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    idle();
    bus.hwint = 6'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_req", {31'h0, bus.req}, 32'h0);
    chk("rst_exl", {31'h0, bus.exl}, 32'h0);
    chk("rst_epc_out", bus.epc_out, 32'h0);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h2022_0707);

    // enable IM[0] and IE, then raise hwint[0]
    bus.mtc0_we_M   = 1'b1;
    bus.cp0_addr_M  = 5'd12;
    bus.cp0_wdata_M = 32'h0000_0401;
    step();
    idle();
    bus.hwint = 6'b000001;
    #1;
    chk("irq_req", {31'h0, bus.req}, 32'h1);
    step();
    chk("irq_exl", {31'h0, bus.exl}, 32'h1);
    rd("irq_cause", 5'd13, 32'h0000_0400);
    rd("irq_epc", 5'd14, 32'h0000_3000);
    rd("irq_sr", 5'd12, 32'h0000_0403);

    // leave handler
    bus.hwint  = 6'd0;
    bus.eret_M = 1'b1;
    step();
    idle();
    #1;
    chk("eret_exl", {31'h0, bus.exl}, 32'h0);
    chk("eret_req", {31'h0, bus.req}, 32'h0);

    // exception in delay slot
    bus.exccode_M = 5'd4;
    bus.bd_M      = 1'b1;
    bus.pc_M      = 32'h0000_3010;
    #1;
    chk("exc_req", {31'h0, bus.req}, 32'h1);
    step();
    #1;
    chk("exc_masked", {31'h0, bus.req}, 32'h0);
    rd("exc_epc", 5'd14, 32'h0000_300C);
    rd("exc_cause", 5'd13, 32'h8000_0010);
    idle();

    // leave handler
    bus.eret_M = 1'b1;
    step();
    idle();

    // irq + exception + mtc0 EPC together
    bus.hwint       = 6'b000001;
    bus.exccode_M   = 5'd10;
    bus.pc_M        = 32'h0000_3020;
    bus.mtc0_we_M   = 1'b1;
    bus.cp0_addr_M  = 5'd14;
    bus.cp0_wdata_M = 32'h0000_DEAD;
    #1;
    chk("both_req", {31'h0, bus.req}, 32'h1);
    chk("both_fwd", bus.epc_out, 32'h0000_DEAD);
    step();
    idle();
    rd("both_cause", 5'd13, 32'h0000_0400);
    rd("both_epc", 5'd14, 32'h0000_3020);
    rd("both_sr", 5'd12, 32'h0000_0403);

    // mtc0 EPC alongside eret
    bus.hwint       = 6'd0;
    bus.eret_M      = 1'b1;
    bus.mtc0_we_M   = 1'b1;
    bus.cp0_addr_M  = 5'd14;
    bus.cp0_wdata_M = 32'h0000_3100;
    #1;
    chk("eret_fwd", bus.epc_out, 32'h0000_3100);
    step();
    idle();
    #1;
    chk("eret2_exl", {31'h0, bus.exl}, 32'h0);
    rd("eret2_epc", 5'd14, 32'h0000_3100);

    // mtc0 SR with EXL set plus eret: EXL ends clear
    bus.eret_M      = 1'b1;
    bus.mtc0_we_M   = 1'b1;
    bus.cp0_addr_M  = 5'd12;
    bus.cp0_wdata_M = 32'h0000_0C03;
    step();
    idle();
    rd("sr_eret", 5'd12, 32'h0000_0C01);

    // writes to Cause are ignored
    bus.mtc0_we_M   = 1'b1;
    bus.cp0_addr_M  = 5'd13;
    bus.cp0_wdata_M = 32'hFFFF_FFFF;
    step();
    idle();
    rd("cause_ro", 5'd13, 32'h0000_0000);

    // reset beats a pending exception
    bus.exccode_M = 5'd7;
    bus.pc_M      = 32'h0000_3040;
    reset         = 1'b1;
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("rst2_exl", {31'h0, bus.exl}, 32'h0);
    rd("rst2_sr", 5'd12, 32'h0);
    rd("rst2_cause", 5'd13, 32'h0);
    rd("rst2_epc", 5'd14, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
